// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding and sizing constants for the sequential divider
package seq_div_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_WIDTH = 4;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
    localparam int CNT_W = cnt_width(DEF_WIDTH);
endpackage

// File: rtl/addsub_unit.sv
// addsub_unit: N-bit ripple add/subtract; sub drives carry-in and inverts b
// ports: a, b (N) operands; sub (1) subtract mode; sum (N) result; cout (1) carry-out (1 = no borrow)
module addsub_unit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N-1:0] bx;
    logic         c;
    always_comb begin
        bx  = b ^ {N{sub}};
        c   = sub;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ bx[i] ^ c;
            c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock, start/done handshake
// ports: clk, rst (sync, active high); start, dividend, divisor (WIDTH) in;
//        busy, done, quotient, remainder (WIDTH), div_by_zero out (all registered)
// optional: define SEQ_DIV_SIGNED_EN for two's complement operands
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);
    state_t           state, nstate;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qsr, dsr, mag, qfix, rfix;
    logic             dz, accept, run;
    logic [WIDTH:0]   shifted, ua, ub, usum;
    logic             usub, ucout;
    assign run     = state == RUN;
    assign accept  = start && !run;
    assign shifted = {prem[WIDTH-1:0], qsr[WIDTH-1]};
    addsub_unit #(.N(WIDTH + 1)) u_addsub (
        .a    (ua),
        .b    (ub),
        .sub  (usub),
        .sum  (usum),
        .cout (ucout)
    );
`ifdef SEQ_DIV_SIGNED_EN
    logic qneg, rneg;
    // Outside RUN the unit negates the dividend; in RUN a negative divisor is
    // added sign-extended, which equals subtracting its magnitude with the same carry meaning.
    assign ua   = run ? shifted : '0;
    assign ub   = run ? {dsr[WIDTH-1], dsr} : {dividend[WIDTH-1], dividend};
    assign usub = run ? ~dsr[WIDTH-1] : 1'b1;
    assign mag  = dividend[WIDTH-1] ? usum[WIDTH-1:0] : dividend;
    assign qfix = qneg ? -qsr : qsr;
    assign rfix = rneg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            qneg <= 1'b0;
            rneg <= 1'b0;
        end else if (accept) begin
            qneg <= (divisor != '0) && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg <= (divisor != '0) && dividend[WIDTH-1];
        end
    end
`else
    assign ua   = shifted;
    assign ub   = {1'b0, dsr};
    assign usub = 1'b1;
    assign mag  = dividend;
    assign qfix = qsr;
    assign rfix = prem[WIDTH-1:0];
`endif
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nstate;
    end
    always_comb begin
        nstate = IDLE;
        if (run)
            nstate = (cnt == '0) ? DONE : RUN;
        else if (accept)
            nstate = (divisor == '0) ? DONE : RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            prem        <= '0;
            qsr         <= '0;
            dsr         <= '0;
            dz          <= 1'b0;
        end else begin
            busy <= nstate == RUN;
            done <= state == DONE;
            if (state == DONE) begin
                quotient    <= qfix;
                remainder   <= rfix;
                div_by_zero <= dz;
            end else if (accept) begin
                div_by_zero <= 1'b0;
            end
            if (accept) begin
                dsr  <= divisor;
                cnt  <= CW'(WIDTH - 1);
                dz   <= divisor == '0;
                qsr  <= (divisor == '0) ? '1 : mag;
                // divide-by-zero parks the raw dividend as the remainder
                prem <= (divisor == '0) ? {1'b0, dividend} : '0;
            end else if (run) begin
                prem <= ucout ? usum : shifted;
                qsr  <= {qsr[WIDTH-2:0], ucout};
                cnt  <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random divide operations checked against a result scoreboard
module tb_seq_divider;
    localparam int W = 4;
    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst, start, busy, done, div_by_zero;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           bsy_cnt;
    always #5 clk = ~clk;
    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        sb.push_back(e);
    endtask
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n       = 0;
        bsy_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            bsy_cnt += int'(busy);
        end while (!done && n < 20);
        chk("latency", n, lat);
    endtask
    always @(negedge clk) begin
        if (done) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_done got=done exp=no_done");
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dz);
            end
        end
    end
    initial begin
        logic [W-1:0] a, b;
        int           n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
`ifdef SEQ_DIV_SIGNED_EN
        push(4'b1101, 4'b1111, 1'b0);
        op(4'b1001, 4'd2, 6);
        push(4'b1000, 4'b0000, 1'b0);
        op(4'b1000, 4'b1111, 6);
        push(4'b1101, 4'b0001, 1'b0);
        op(4'd7, 4'b1110, 6);
        push(4'hF, 4'd9, 1'b1);
        op(4'd9, 4'd0, 2);
        push(4'd2, 4'd1, 1'b0);
        op(4'd7, 4'd3, 6);
`else
        push(4'd4, 4'd1, 1'b0);
        op(4'd13, 4'd3, 6);
        chk("busy_cycles", bsy_cnt, 4);
        push(4'd15, 4'd0, 1'b0);
        push(4'd0, 4'd5, 1'b0);
        @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 dividend = 4'd5;
        divisor = 4'd7;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_done1", done, 1);
        chk("b2b_busy", busy, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        chk("b2b_latency", n, 5);
        push(4'hF, 4'd9, 1'b1);
        op(4'd9, 4'd0, 2);
        push(4'd4, 4'd0, 1'b0);
        op(4'd8, 4'd2, 6);
        push(4'd2, 4'd2, 1'b0);
        @(negedge clk);
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 dividend = 4'd7;
        divisor = 4'd7;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        chk("ignored_busy", busy, 0);
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dz", div_by_zero, 0);
        repeat (8) @(negedge clk);
        push(4'd4, 4'd2, 1'b0);
        op(4'd14, 4'd3, 6);
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(1, 15));
            push(a / b, a % b, 1'b0);
            op(a, b, 6);
        end
`endif
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring integer divider: the inverse operation to the team's ripple add/subtract datapath.
- Computes quotient and remainder of dividend / divisor, producing one quotient bit per clock.
- Each trial subtraction reuses an add/subtract unit in subtract mode (carry-in = 1, B inverted).
- Sits beside the 4-bit adder/subtracter as the team's first clocked arithmetic block, with a start/done handshake.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (min 2).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- dividend  input  WIDTH  numerator, captured when start is accepted.
- divisor  input  WIDTH  denominator, captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: results valid.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor == 0; held with the results.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state = IDLE.
  - busy, done, div_by_zero = 0.
  - quotient, remainder = 0.
  - iteration counter = 0.
  - Applies from any state, including mid-RUN; the in-flight operation is discarded.
- States: IDLE, RUN, DONE. Registered outputs only.
- IDLE:
  - start=1 with divisor != 0: load operands; partial remainder = 0; quotient shift register = dividend; counter = WIDTH-1; go to RUN.
  - start=1 with divisor == 0: go to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN, one iteration per cycle:
  - Shift {partial_rem[WIDTH:0], q} left by 1.
  - Trial = shifted partial_rem - {0, divisor}, computed WIDTH+1 bits wide via the add/sub unit.
  - Carry-out 1 (no borrow): partial_rem = trial and the new q LSB = 1.
  - Carry-out 0 (borrow): restore partial_rem and the new q LSB = 0.
  - Counter decrements each cycle. The iteration at counter == 0 is the last; go to DONE.
- DONE:
  - done = 1 for exactly this cycle; quotient/remainder outputs are updated on entry.
  - Next cycle goes to IDLE.
  - start=1 during DONE is accepted exactly as in IDLE (back-to-back operation).
- Latency:
  - start sampled at edge N gives done high in the cycle following edge N+WIDTH+1 (divisor != 0).
  - Divide-by-zero: done follows edge N+1.
- start while busy: ignored; operands are not recaptured and there is no error flag.
- Operand changes after acceptance: no effect.
- div_by_zero clears on the next accepted start.
- Invariant (unsigned): dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are formed on capture by negating negative operands through the add/sub unit.
  - Quotient is negated when the operand signs differ; remainder takes the sign of the dividend. Both corrections are applied on DONE entry.
  - Latency is unchanged.
  - Overflow case, most-negative / -1: quotient = most-negative (wraps), remainder = 0, no flag.
  - Divide by zero: quotient = all ones (-1), remainder = dividend.
- Undefined: unsigned operation only; no sign logic is synthesised.

Decomposition:
- Package seq_div_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
  - Counter width constant, $clog2(WIDTH).
- Sub-module addsub_unit:
  - WIDTH+1-bit ripple add/subtract with a sub input used as carry-in and B-invert.
  - Outputs sum and carry-out.
  - Instantiated once for the trial subtract; under SEQ_DIV_SIGNED_EN it is time-shared for negation.

Test Plan:
- 13/3 (WIDTH=4, start at edge 0) -> done in the cycle after edge 5; quotient=4, remainder=1, div_by_zero=0; busy high for 4 cycles.
- 15/1 then 5/7 back-to-back (second start asserted during DONE) -> q=15 r=0, then q=0 r=5; no idle cycle between the operations.
- 9/0 -> done in the cycle after edge 1; quotient=4'hF, remainder=9, div_by_zero=1; next 8/2 -> q=4 r=0, div_by_zero=0.
- 12/5 accepted, then start with 7/7 held during RUN -> single result q=2 r=2; the 7/7 request is ignored.
- 14/3 started, rst pulsed for one cycle at iteration 2 -> all outputs 0, state IDLE; a following 14/3 -> q=4 r=2.
- SEQ_DIV_SIGNED_EN: -7/2 -> q=4'b1101 (-3), r=4'b1111 (-1); -8/-1 -> q=4'b1000, r=0; 7/-2 -> q=-3, r=1.
